multi_reg_sequencer: RTL and testbench

Sequences multi-register Thumb transfers (PUSH, POP, STMIA, LDMIA) into a stream of single-register load/store micro-ops, one per cycle, plus a final base-register writeback micro-op. It sits between decode and the register-file read/write address path. While it is active it stalls fetch and decode. Each micro-op carries the register address, the base register address and a signed byte offset from the base register's value at instruction start.

---
 rtl/multi_reg_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_multi_reg_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_reg_sequencer.sv
// Breaks Thumb PUSH/POP/STMIA/LDMIA into single-register load/store micro-ops
// plus an optional base writeback micro-op, one per cycle, all outputs registered.
module multi_reg_sequencer #(
   parameter int unsigned ADDR_WIDTH   = 4,
   parameter int unsigned OFFSET_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [15:0]             instruction_i,
   output logic                    start_ready_o,
   output logic                    busy_o,
   output logic                    uop_valid_o,
   input  logic                    uop_ready_i,
   output logic                    uop_is_load_o,
   output logic                    uop_is_wb_o,
   output logic [ADDR_WIDTH-1:0]   uop_reg_o,
   output logic [ADDR_WIDTH-1:0]   uop_base_o,
   output logic [OFFSET_WIDTH-1:0] uop_offset_o,
   output logic                    uop_last_o
);

   localparam int unsigned LIST_WIDTH = 9;
   localparam int unsigned IDX_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t                         state, state_next;
   logic [LIST_WIDTH-1:0]          list, list_next;
   logic                           is_load, is_load_next;
   logic                           wb_en, wb_en_next;
   logic [ADDR_WIDTH-1:0]          base, base_next;
   logic [ADDR_WIDTH-1:0]          hi_reg, hi_reg_next;
   logic signed [OFFSET_WIDTH-1:0] offset, offset_next;
   logic signed [OFFSET_WIDTH-1:0] wb_offset, wb_offset_next;

   logic                           is_push, is_pop, is_stm, is_ldm, legal;
   logic [LIST_WIDTH-1:0]          dec_list;
   logic [IDX_WIDTH-1:0]           dec_count;
   logic signed [OFFSET_WIDTH-1:0] dec_span;

   logic [LIST_WIDTH-1:0]          rest_next;
   logic [IDX_WIDTH-1:0]           low_next;
   logic                           load_d, wb_d, last_d;
   logic [ADDR_WIDTH-1:0]          reg_d, base_d;
   logic [OFFSET_WIDTH-1:0]        offset_d;

   function automatic logic [IDX_WIDTH-1:0] popcount(input logic [LIST_WIDTH-1:0] v);
      logic [IDX_WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < int'(LIST_WIDTH); i++) c = c + IDX_WIDTH'(v[i]);
      return c;
   endfunction

   function automatic logic [IDX_WIDTH-1:0] lowest(input logic [LIST_WIDTH-1:0] v);
      logic [IDX_WIDTH-1:0] idx;
      idx = '0;
      for (int i = int'(LIST_WIDTH) - 1; i >= 0; i--) if (v[i]) idx = IDX_WIDTH'(i);
      return idx;
   endfunction

   // Instruction decode; only consumed when idle and start_i is high
   always_comb begin
      is_push   = (instruction_i[15:9] == 7'b1011010);
      is_pop    = (instruction_i[15:9] == 7'b1011110);
      is_stm    = (instruction_i[15:11] == 5'b11000);
      is_ldm    = (instruction_i[15:11] == 5'b11001);
      legal     = is_push | is_pop | is_stm | is_ldm;
      dec_list  = (is_push | is_pop) ? instruction_i[8:0] : {1'b0, instruction_i[7:0]};
      dec_count = popcount(dec_list);
      dec_span  = OFFSET_WIDTH'({dec_count, 2'b00});
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= IDLE;
         list      <= '0;
         is_load   <= 1'b0;
         wb_en     <= 1'b0;
         base      <= '0;
         hi_reg    <= '0;
         offset    <= '0;
         wb_offset <= '0;
      end else begin
         state     <= state_next;
         list      <= list_next;
         is_load   <= is_load_next;
         wb_en     <= wb_en_next;
         base      <= base_next;
         hi_reg    <= hi_reg_next;
         offset    <= offset_next;
         wb_offset <= wb_offset_next;
      end
   end

   // Next state plus next-cycle micro-op fields, so the outputs can be registered
   always_comb begin
      state_next     = state;
      list_next      = list;
      is_load_next   = is_load;
      wb_en_next     = wb_en;
      base_next      = base;
      hi_reg_next    = hi_reg;
      offset_next    = offset;
      wb_offset_next = wb_offset;
      rest_next      = '0;
      low_next       = '0;
      load_d         = 1'b0;
      wb_d           = 1'b0;
      last_d         = 1'b0;
      reg_d          = '0;
      base_d         = '0;
      offset_d       = '0;

      case (state)
         IDLE: begin
            if (start_i && legal && (dec_count != '0)) begin
               state_next     = XFER;
               list_next      = dec_list;
               is_load_next   = is_pop | is_ldm;
               base_next      = (is_push | is_pop) ? ADDR_WIDTH'(13)
                                                   : ADDR_WIDTH'(instruction_i[10:8]);
               hi_reg_next    = is_pop ? ADDR_WIDTH'(15) : ADDR_WIDTH'(14);
               offset_next    = is_push ? -dec_span : '0;
               wb_offset_next = is_push ? -dec_span : dec_span;
               wb_en_next     = !(is_ldm && dec_list[instruction_i[10:8]]);
            end
         end
         XFER: begin
            if (uop_ready_i) begin
               list_next   = list & (list - LIST_WIDTH'(1));
               offset_next = offset + OFFSET_WIDTH'(4);
               if (list_next == '0) state_next = wb_en ? WB : IDLE;
            end
         end
         WB: begin
            if (uop_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      rest_next = list_next & (list_next - LIST_WIDTH'(1));
      low_next  = lowest(list_next);
      if (state_next == XFER) begin
         load_d   = is_load_next;
         reg_d    = (low_next == IDX_WIDTH'(8)) ? hi_reg_next : ADDR_WIDTH'(low_next);
         base_d   = base_next;
         offset_d = offset_next;
         last_d   = (rest_next == '0) && !wb_en_next;
      end else if (state_next == WB) begin
         wb_d     = 1'b1;
         reg_d    = base_next;
         base_d   = base_next;
         offset_d = wb_offset_next;
         last_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         start_ready_o <= 1'b1;
         busy_o        <= 1'b0;
         uop_valid_o   <= 1'b0;
         uop_is_load_o <= 1'b0;
         uop_is_wb_o   <= 1'b0;
         uop_reg_o     <= '0;
         uop_base_o    <= '0;
         uop_offset_o  <= '0;
         uop_last_o    <= 1'b0;
      end else begin
         start_ready_o <= (state_next == IDLE);
         busy_o        <= (state_next != IDLE);
         uop_valid_o   <= (state_next != IDLE);
         uop_is_load_o <= load_d;
         uop_is_wb_o   <= wb_d;
         uop_reg_o     <= reg_d;
         uop_base_o    <= base_d;
         uop_offset_o  <= offset_d;
         uop_last_o    <= last_d;
      end
   end

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Directed bench for multi_reg_sequencer: PUSH/POP/LDMIA/STMIA sequences,
// backpressure, mid-sequence reset and ignored starts.
module tb_multi_reg_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] instr;
   logic        start_ready;
   logic        busy;
   logic        uop_valid;
   logic        uop_ready;
   logic        uop_is_load;
   logic        uop_is_wb;
   logic [3:0]  uop_reg;
   logic [3:0]  uop_base;
   logic [7:0]  uop_offset;
   logic        uop_last;

   int total = 0;
   int bad   = 0;

   multi_reg_sequencer #(.ADDR_WIDTH(4), .OFFSET_WIDTH(8)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .instruction_i (instr),
      .start_ready_o (start_ready),
      .busy_o        (busy),
      .uop_valid_o   (uop_valid),
      .uop_ready_i   (uop_ready),
      .uop_is_load_o (uop_is_load),
      .uop_is_wb_o   (uop_is_wb),
      .uop_reg_o     (uop_reg),
      .uop_base_o    (uop_base),
      .uop_offset_o  (uop_offset),
      .uop_last_o    (uop_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Inputs are driven and outputs sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {valid, load, wb, reg, base, offset, last}
   function automatic logic [19:0] obs();
      return {uop_valid, uop_is_load, uop_is_wb, uop_reg, uop_base, uop_offset, uop_last};
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; instr = 16'h0000; uop_ready = 1'b0;
      tick(); tick();
      total++;
      if ({start_ready, busy, obs()} !== {1'b1, 1'b0, 20'h0}) begin
         bad++;
         $display("FAIL reset_state got=%h exp=%h", {start_ready, busy, obs()}, {1'b1, 1'b0, 20'h0});
      end
      reset = 1'b0;
      tick();
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL reset_release got=%b exp=100", {start_ready, busy, uop_valid});
      end
   endtask

   task automatic test_push();
      int er [4] = '{0, 2, 14, 13};
      int eo [4] = '{-12, -8, -4, -12};
      logic [19:0] exp;
      int busy_cnt;
      busy_cnt = 0;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hB505;
      tick();
      start = 1'b0;
      total++;
      if (start_ready !== 1'b0) begin
         bad++;
         $display("FAIL push_ready_drop got=%b exp=0", start_ready);
      end
      for (int i = 0; i < 4; i++) begin
         exp = {1'b1, 1'b0, i == 3, 4'(er[i]), 4'd13, 8'(eo[i]), i == 3};
         total++;
         if (obs() !== exp) begin
            bad++;
            $display("FAIL push_uop%0d got=%h exp=%h", i, obs(), exp);
         end
         if (busy === 1'b1) busy_cnt++;
         tick();
      end
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL push_idle got=%b exp=100", {start_ready, busy, uop_valid});
      end
      total++;
      if (busy_cnt !== 4) begin
         bad++;
         $display("FAIL push_busy_cycles got=%0d exp=4", busy_cnt);
      end
   endtask

   task automatic test_pop();
      int er [3] = '{1, 15, 13};
      int eo [3] = '{0, 4, 8};
      logic [19:0] exp;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hBD02;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp = {1'b1, i < 2, i == 2, 4'(er[i]), 4'd13, 8'(eo[i]), i == 2};
         total++;
         if (obs() !== exp) begin
            bad++;
            $display("FAIL pop_uop%0d got=%h exp=%h", i, obs(), exp);
         end
         tick();
      end
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL pop_ready_return got=%b exp=100", {start_ready, busy, uop_valid});
      end
   endtask

   task automatic test_ldm_nowb();
      int er [2] = '{3, 4};
      int eo [2] = '{0, 4};
      logic [19:0] exp;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hCB18;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp = {1'b1, 1'b1, 1'b0, 4'(er[i]), 4'd3, 8'(eo[i]), i == 1};
         total++;
         if (obs() !== exp) begin
            bad++;
            $display("FAIL ldm_uop%0d got=%h exp=%h", i, obs(), exp);
         end
         tick();
      end
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL ldm_no_wb got=%b exp=100", {start_ready, busy, uop_valid});
      end
   endtask

   task automatic test_empty();
      uop_ready = 1'b1; start = 1'b1; instr = 16'hC000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({start_ready, busy, uop_valid} !== 3'b100) begin
            bad++;
            $display("FAIL empty_list%0d got=%b exp=100", i, {start_ready, busy, uop_valid});
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int er [5] = '{4, 5, 6, 7, 13};
      int eo [5] = '{-16, -12, -8, -4, -16};
      logic [19:0] exp;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hB4F0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp = {1'b1, 1'b0, i == 4, 4'(er[i]), 4'd13, 8'(eo[i]), i == 4};
         if (i == 1) begin
            uop_ready = 1'b0;
            for (int h = 0; h < 3; h++) begin
               total++;
               if (obs() !== exp) begin
                  bad++;
                  $display("FAIL bp_hold%0d got=%h exp=%h", h, obs(), exp);
               end
               tick();
            end
            uop_ready = 1'b1;
         end
         total++;
         if (obs() !== exp) begin
            bad++;
            $display("FAIL bp_uop%0d got=%h exp=%h", i, obs(), exp);
         end
         tick();
      end
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL bp_idle got=%b exp=100", {start_ready, busy, uop_valid});
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] exp;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hBCFF;
      tick();
      start = 1'b0;
      exp = {1'b1, 1'b1, 1'b0, 4'd0, 4'd13, 8'd0, 1'b0};
      total++;
      if (obs() !== exp) begin
         bad++;
         $display("FAIL rmid_uop0 got=%h exp=%h", obs(), exp);
      end
      tick();
      exp = {1'b1, 1'b1, 1'b0, 4'd1, 4'd13, 8'd4, 1'b0};
      total++;
      if (obs() !== exp) begin
         bad++;
         $display("FAIL rmid_uop1 got=%h exp=%h", obs(), exp);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({start_ready, busy, obs()} !== {1'b1, 1'b0, 20'h0}) begin
            bad++;
            $display("FAIL rmid_abandon%0d got=%h exp=%h", i, {start_ready, busy, obs()},
                     {1'b1, 1'b0, 20'h0});
         end
         tick();
      end
      start = 1'b1; instr = 16'hB401;
      tick();
      start = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 4'd0, 4'd13, 8'hFC, 1'b0};
      total++;
      if (obs() !== exp) begin
         bad++;
         $display("FAIL rmid_push_str got=%h exp=%h", obs(), exp);
      end
      tick();
      exp = {1'b1, 1'b0, 1'b1, 4'd13, 4'd13, 8'hFC, 1'b1};
      total++;
      if (obs() !== exp) begin
         bad++;
         $display("FAIL rmid_push_wb got=%h exp=%h", obs(), exp);
      end
      tick();
      total++;
      if ({start_ready, busy, uop_valid} !== 3'b100) begin
         bad++;
         $display("FAIL rmid_push_idle got=%b exp=100", {start_ready, busy, uop_valid});
      end
   endtask

   task automatic test_illegal();
      uop_ready = 1'b1; start = 1'b1; instr = 16'h1888;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({start_ready, busy, uop_valid} !== 3'b100) begin
            bad++;
            $display("FAIL illegal%0d got=%b exp=100", i, {start_ready, busy, uop_valid});
         end
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_busy_start();
      int er [4] = '{0, 2, 14, 13};
      int eo [4] = '{-12, -8, -4, -12};
      logic [19:0] exp;
      uop_ready = 1'b1; start = 1'b1; instr = 16'hB505;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp = {1'b1, 1'b0, i == 3, 4'(er[i]), 4'd13, 8'(eo[i]), i == 3};
         total++;
         if (obs() !== exp) begin
            bad++;
            $display("FAIL busy_start_uop%0d got=%h exp=%h", i, obs(), exp);
         end
         if (i == 1) begin
            start = 1'b1; instr = 16'hBD02;
         end else begin
            start = 1'b0; instr = 16'hB505;
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({start_ready, busy, uop_valid} !== 3'b100) begin
            bad++;
            $display("FAIL busy_start_idle%0d got=%b exp=100", i, {start_ready, busy, uop_valid});
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pop();
      test_ldm_nowb();
      test_empty();
      test_backpressure();
      test_reset_mid();
      test_illegal();
      test_busy_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
